// File: rtl/multi_bank_pp_buffer_pkg.sv
// Shared helpers for the multi-bank ping-pong buffer: bank pointer
// arithmetic and the bank-index width.
package pp_buf_pkg;

  function automatic int ptr_inc(input int ptr, input int n);
    return (ptr >= n - 1) ? 0 : ptr + 1;
  endfunction

  // A single bank still needs a one-bit pointer to keep vector widths legal.
  function automatic int bank_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multi_bank_pp_buffer_if.sv
// Write/read/status bundle of the multi-bank ping-pong buffer.
interface pp_buf_if #(
  parameter int BIT_LENGTH = 64,
  parameter int DEPTH      = 16,
  parameter int NUM_BANKS  = 2
);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(NUM_BANKS + 1);

  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [BIT_LENGTH-1:0] wr_data;
  logic                  wr_commit;
  logic                  wr_ready;
  logic                  rd_en;
  logic [AW-1:0]         rd_addr;
  logic [BIT_LENGTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_bank_valid;
  logic                  rd_release;
  logic [BW-1:0]         full_cnt;
  logic                  err;

  modport master (
    output wr_en, wr_addr, wr_data, wr_commit, rd_en, rd_addr, rd_release,
    input  wr_ready, rd_data, rd_valid, rd_bank_valid, full_cnt, err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_commit, rd_en, rd_addr, rd_release,
    output wr_ready, rd_data, rd_valid, rd_bank_valid, full_cnt, err
  );
endinterface

// File: rtl/multi_bank_pp_buffer_ram.sv
// Simple dual-port RAM holding all banks back to back; read-first with a
// registered read port that holds its value when not reading.
module pp_bank_ram #(
  parameter int BIT_LENGTH = 64,
  parameter int WORDS      = 32,
  parameter int MW         = $clog2(WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [MW-1:0]         waddr,
  input  logic [BIT_LENGTH-1:0] wdata,
  input  logic                  re,
  input  logic [MW-1:0]         raddr,
  output logic [BIT_LENGTH-1:0] rdata
);
  logic [BIT_LENGTH-1:0] mem [WORDS];

  // Storage is never reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/multi_bank_pp_buffer.sv
// Circular queue of NUM_BANKS buffers: the writer fills and commits banks,
// the reader consumes and releases them in the same order.
module multi_bank_pp_buffer
  import pp_buf_pkg::*;
#(
  parameter int BIT_LENGTH = 64,
  parameter int DEPTH      = 16,
  parameter int NUM_BANKS  = 2
) (
  input logic   clk,
  input logic   rst,
  pp_buf_if.slave bus
);
  localparam int AW    = $clog2(DEPTH);
  localparam int BW    = $clog2(NUM_BANKS + 1);
  localparam int PW    = bank_w(NUM_BANKS);
  localparam int WORDS = NUM_BANKS * DEPTH;
  localparam int MW    = $clog2(WORDS);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [BW-1:0] full_cnt;
  logic          rd_valid, err;
  logic          wr_ready, rd_bank_valid;
  logic          wr_in_range, rd_in_range;
  logic          wr_ok, commit_ok, rd_ok, rel_ok, err_set;
  logic [MW-1:0] wr_phys, rd_phys;

  assign wr_ready      = full_cnt < BW'(NUM_BANKS);
  assign rd_bank_valid = full_cnt != '0;
  assign wr_in_range   = {1'b0, bus.wr_addr} < DEPTH_C;
  assign rd_in_range   = {1'b0, bus.rd_addr} < DEPTH_C;

  // Every qualifier uses pre-edge state, so commit+release in one cycle both land.
  assign wr_ok     = bus.wr_en && wr_ready && wr_in_range && !rst;
  assign commit_ok = bus.wr_commit && wr_ready;
  assign rd_ok     = bus.rd_en && rd_bank_valid && rd_in_range && !rst;
  assign rel_ok    = bus.rd_release && rd_bank_valid;
  assign err_set   = (bus.wr_en && !(wr_ready && wr_in_range)) ||
                     (bus.wr_commit && !wr_ready) ||
                     (bus.rd_en && !(rd_bank_valid && rd_in_range)) ||
                     (bus.rd_release && !rd_bank_valid);

  assign wr_phys = MW'(wr_ptr) * MW'(DEPTH) + MW'(bus.wr_addr);
  assign rd_phys = MW'(rd_ptr) * MW'(DEPTH) + MW'(bus.rd_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      full_cnt <= '0;
      rd_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      if (commit_ok) wr_ptr <= PW'(ptr_inc(int'(wr_ptr), NUM_BANKS));
      if (rel_ok)    rd_ptr <= PW'(ptr_inc(int'(rd_ptr), NUM_BANKS));
      case ({commit_ok, rel_ok})
        2'b10:   full_cnt <= full_cnt + BW'(1);
        2'b01:   full_cnt <= full_cnt - BW'(1);
        default: full_cnt <= full_cnt;
      endcase
      if (err_set) err <= 1'b1;
    end
  end

  pp_bank_ram #(
    .BIT_LENGTH (BIT_LENGTH),
    .WORDS      (WORDS),
    .MW         (MW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok),
    .waddr (wr_phys),
    .wdata (bus.wr_data),
    .re    (rd_ok),
    .raddr (rd_phys),
    .rdata (bus.rd_data)
  );

  assign bus.wr_ready      = wr_ready;
  assign bus.rd_bank_valid = rd_bank_valid;
  assign bus.full_cnt      = full_cnt;
  assign bus.rd_valid      = rd_valid;
  assign bus.err           = err;
endmodule

// File: tb/tb_multi_bank_pp_buffer.sv
// Directed bench: a 2-bank/16-word instance for basic ping-pong and a
// 3-bank/12-word instance for fill, overlap, wrap, error and reset cases.
module tb_multi_bank_pp_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  pp_buf_if #(.BIT_LENGTH(64), .DEPTH(16), .NUM_BANKS(2)) ifa ();
  pp_buf_if #(.BIT_LENGTH(16), .DEPTH(12), .NUM_BANKS(3)) ifb ();

  multi_bank_pp_buffer #(.BIT_LENGTH(64), .DEPTH(16), .NUM_BANKS(2)) dut_a (
    .clk (clk), .rst (rst), .bus (ifa.slave)
  );
  multi_bank_pp_buffer #(.BIT_LENGTH(16), .DEPTH(12), .NUM_BANKS(3)) dut_b (
    .clk (clk), .rst (rst), .bus (ifb.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_a();
    ifa.wr_en = 0; ifa.wr_addr = '0; ifa.wr_data = '0; ifa.wr_commit = 0;
    ifa.rd_en = 0; ifa.rd_addr = '0; ifa.rd_release = 0;
  endtask

  task automatic idle_b();
    ifb.wr_en = 0; ifb.wr_addr = '0; ifb.wr_data = '0; ifb.wr_commit = 0;
    ifb.rd_en = 0; ifb.rd_addr = '0; ifb.rd_release = 0;
  endtask

  initial begin
    idle_a();
    idle_b();
    rst = 1;
    step();
    step();
    rst = 0;

    chk("a_rst_full_cnt", 64'(ifa.full_cnt), 0);
    chk("a_rst_wr_ready", 64'(ifa.wr_ready), 1);
    chk("a_rst_rd_bank_valid", 64'(ifa.rd_bank_valid), 0);
    chk("a_rst_rd_valid", 64'(ifa.rd_valid), 0);
    chk("a_rst_rd_data", ifa.rd_data, 0);
    chk("a_rst_err", 64'(ifa.err), 0);

    // Basic ping-pong: fill bank 0, commit, read back.
    for (int i = 0; i < 16; i++) begin
      ifa.wr_en = 1; ifa.wr_addr = 4'(i); ifa.wr_data = 64'h100 + 64'(i);
      step();
    end
    ifa.wr_en = 0; ifa.wr_commit = 1;
    step();
    ifa.wr_commit = 0;
    chk("a_commit_full_cnt", 64'(ifa.full_cnt), 1);
    chk("a_commit_rd_bank_valid", 64'(ifa.rd_bank_valid), 1);
    chk("a_commit_wr_ready", 64'(ifa.wr_ready), 1);
    for (int i = 0; i < 16; i++) begin
      ifa.rd_en = 1; ifa.rd_addr = 4'(i);
      step();
      chk("a_pp_rd_valid", 64'(ifa.rd_valid), 1);
      chk("a_pp_rd_data", ifa.rd_data, 64'h100 + 64'(i));
    end
    ifa.rd_en = 0;
    step();
    chk("a_idle_rd_valid", 64'(ifa.rd_valid), 0);
    chk("a_idle_rd_hold", ifa.rd_data, 64'h10F);
    ifa.rd_release = 1;
    step();
    ifa.rd_release = 0;
    chk("a_release_full_cnt", 64'(ifa.full_cnt), 0);

    // Write and commit together into bank 1, then read and release together.
    ifa.wr_en = 1; ifa.wr_addr = 0; ifa.wr_data = 64'hAAAA; ifa.wr_commit = 1;
    step();
    idle_a();
    chk("a_wc_full_cnt", 64'(ifa.full_cnt), 1);
    ifa.rd_en = 1; ifa.rd_addr = 0; ifa.rd_release = 1;
    step();
    idle_a();
    chk("a_rr_rd_data", ifa.rd_data, 64'hAAAA);
    chk("a_rr_rd_valid", 64'(ifa.rd_valid), 1);
    chk("a_rr_full_cnt", 64'(ifa.full_cnt), 0);
    chk("a_rr_err", 64'(ifa.err), 0);

    // Fill all three banks of instance B.
    for (int b = 0; b < 3; b++) begin
      ifb.wr_en = 1; ifb.wr_addr = 3; ifb.wr_data = 16'h1000 + 16'(b); ifb.wr_commit = 1;
      step();
    end
    idle_b();
    chk("b_fill_full_cnt", 64'(ifb.full_cnt), 3);
    chk("b_fill_wr_ready", 64'(ifb.wr_ready), 0);
    chk("b_fill_err", 64'(ifb.err), 0);
    ifb.wr_en = 1; ifb.wr_addr = 3; ifb.wr_data = 16'hDEAD;
    step();
    idle_b();
    chk("b_full_write_err", 64'(ifb.err), 1);
    chk("b_full_write_cnt", 64'(ifb.full_cnt), 3);
    ifb.rd_en = 1; ifb.rd_addr = 3; ifb.rd_release = 1;
    step();
    idle_b();
    chk("b_full_mem_kept", ifb.rd_data, 16'h1000);
    chk("b_err_sticky", 64'(ifb.err), 1);
    chk("b_after_rel_cnt", 64'(ifb.full_cnt), 2);

    // Reset with two banks pending and every request active.
    rst = 1;
    ifb.rd_en = 1; ifb.rd_addr = 3; ifb.rd_release = 1;
    ifb.wr_en = 1; ifb.wr_addr = 0; ifb.wr_commit = 1;
    step();
    rst = 0;
    idle_b();
    chk("b_midrst_full_cnt", 64'(ifb.full_cnt), 0);
    chk("b_midrst_rd_valid", 64'(ifb.rd_valid), 0);
    chk("b_midrst_rd_data", ifb.rd_data, 0);
    chk("b_midrst_err", 64'(ifb.err), 0);
    chk("b_midrst_wr_ptr", 64'(dut_b.wr_ptr), 0);

    // Address beyond DEPTH is rejected.
    ifb.wr_en = 1; ifb.wr_addr = 12; ifb.wr_data = 16'hBEEF;
    step();
    idle_b();
    chk("b_oob_err", 64'(ifb.err), 1);
    rst = 1;
    step();
    rst = 0;

    // Simultaneous commit and release with one bank pending.
    ifb.wr_en = 1; ifb.wr_addr = 0; ifb.wr_data = 16'h2000; ifb.wr_commit = 1;
    step();
    ifb.wr_data = 16'h2001; ifb.rd_release = 1;
    step();
    idle_b();
    chk("b_sim_full_cnt", 64'(ifb.full_cnt), 1);
    chk("b_sim_wr_ptr", 64'(dut_b.wr_ptr), 2);
    chk("b_sim_rd_ptr", 64'(dut_b.rd_ptr), 1);
    ifb.rd_en = 1; ifb.rd_addr = 0;
    step();
    idle_b();
    chk("b_sim_rd_data", ifb.rd_data, 16'h2001);
    chk("b_sim_err", 64'(ifb.err), 0);

    // Wraparound: seven tagged commits, each overlapped with reading the previous one.
    rst = 1;
    step();
    rst = 0;
    for (int k = 0; k < 7; k++) begin
      ifb.wr_en = 1; ifb.wr_addr = 1; ifb.wr_data = 16'h30 + 16'(k); ifb.wr_commit = 1;
      ifb.rd_en = (k > 0); ifb.rd_addr = 1; ifb.rd_release = (k > 0);
      step();
      if (k > 0) chk("b_wrap_tag", ifb.rd_data, 16'h30 + 16'(k - 1));
      chk("b_wrap_full_cnt", 64'(ifb.full_cnt), 1);
    end
    idle_b();
    ifb.rd_en = 1; ifb.rd_addr = 1; ifb.rd_release = 1;
    step();
    idle_b();
    chk("b_wrap_last_tag", ifb.rd_data, 16'h36);
    chk("b_wrap_wr_ptr", 64'(dut_b.wr_ptr), 1);
    chk("b_wrap_rd_ptr", 64'(dut_b.rd_ptr), 1);
    chk("b_wrap_empty", 64'(ifb.full_cnt), 0);
    chk("b_wrap_err", 64'(ifb.err), 0);

    // Release on an empty queue is rejected without underflow.
    ifb.rd_release = 1;
    step();
    idle_b();
    chk("b_empty_rel_err", 64'(ifb.err), 1);
    chk("b_empty_rel_cnt", 64'(ifb.full_cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/multi_bank_pp_buffer.md
MULTI_BANK_PP_BUFFER -- requirements
Module: multi_bank_pp_buffer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- BIT_LENGTH, 64, data word width.
- DEPTH, 16, words per bank, >=2, any integer.
- NUM_BANKS, 2, bank count, >=2, any integer.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning. AW = $clog2(DEPTH); BW = $clog2(NUM_BANKS+1).
- clk, in, 1, single clock; all logic on posedge.
- rst, in, 1, synchronous, active-high reset.
- wr_en, in, 1, write wr_data into the current write bank.
- wr_addr, in, AW, word address within the write bank.
- wr_data, in, BIT_LENGTH, write data.
- wr_commit, in, 1, hand the write bank to the reader.
- wr_ready, out, 1, a free write bank exists.
- rd_en, in, 1, read request on the current read bank.
- rd_addr, in, AW, word address within the read bank.
- rd_data, out, BIT_LENGTH, read data, registered.
- rd_valid, out, 1, rd_data was updated this cycle.
- rd_bank_valid, out, 1, at least one committed bank is available.
- rd_release, in, 1, return the read bank to the writer.
- full_cnt, out, BW, number of committed, unreleased banks.
- err, out, 1, sticky protocol-violation flag.

Function
REQ-003 Banks SHALL form a circular queue: wr_ptr selects the write bank and rd_ptr the read bank; both wrap from NUM_BANKS-1 to 0.
REQ-004 wr_ready SHALL equal (full_cnt < NUM_BANKS); rd_bank_valid SHALL equal (full_cnt > 0); both are combinational from registered state.
REQ-005 A write SHALL occur when wr_en && wr_ready, storing to physical word wr_ptr*DEPTH + wr_addr.
REQ-006 When wr_commit && wr_ready, wr_ptr SHALL advance and full_cnt SHALL increment at the next edge.
REQ-007 When wr_en and wr_commit are asserted in the same cycle, the write SHALL land in the bank being committed.
REQ-008 A read SHALL occur when rd_en && rd_bank_valid: rd_data <= word rd_ptr*DEPTH + rd_addr, with rd_valid=1 in the next cycle (latency 1).
REQ-009 When no read occurs, rd_valid SHALL be 0 and rd_data SHALL hold its value.
REQ-010 When rd_release && rd_bank_valid, rd_ptr SHALL advance and full_cnt SHALL decrement.
REQ-011 When rd_en and rd_release are asserted in the same cycle, the read SHALL use the bank being released.
REQ-012 A commit and a release in the same cycle SHALL both take effect; full_cnt is unchanged. The qualifying conditions are evaluated on pre-edge state.
REQ-013 A write or read to the same physical word in the same cycle SHALL return the old data (read-first).
REQ-014 wr_en or wr_commit while !wr_ready, rd_en or rd_release while !rd_bank_valid, or wr_addr/rd_addr >= DEPTH SHALL be ignored and SHALL set err.
REQ-015 err SHALL stay set until rst.
REQ-016 Bank contents SHALL be preserved across wraparound until overwritten.

Reset
REQ-017 On rst: wr_ptr=0, rd_ptr=0, full_cnt=0, rd_valid=0, rd_data=0, err=0. Hence wr_ready=1 and rd_bank_valid=0.
REQ-018 Memory contents SHALL NOT be reset.
REQ-019 rst asserted mid-operation SHALL discard all committed banks; same-cycle wr_en, rd_en, commit and release SHALL have no effect on state.

Structure
REQ-020 A package pp_buf_pkg SHALL hold a ptr_inc function that does modulo-NUM_BANKS increment, and the bank-index width helper.
REQ-021 Storage SHALL be one sub-module, pp_bank_ram: a simple dual-port RAM with NUM_BANKS*DEPTH words, read-first behaviour and a registered read.
REQ-022 Pointer, count and error logic SHALL reside in multi_bank_pp_buffer.

Verification
REQ-023 Basic ping-pong (NUM_BANKS=2, DEPTH=16):
- Stimulus: write 0..15 as addr+0x100, commit, read addrs 0..15.
- Response: rd_data = 0x100..0x10F, one cycle after each rd_en.
REQ-024 Fill (NUM_BANKS=3):
- Stimulus: commit 3 banks.
- Response: full_cnt=3, wr_ready=0. A further wr_en sets err and leaves memory unchanged.
REQ-025 Simultaneous (full_cnt=1):
- Stimulus: commit and release in the same cycle.
- Response: full_cnt stays 1, both pointers advance, the next read returns the newly committed data.
REQ-026 Wrap (NUM_BANKS=3):
- Stimulus: 7 commit/release cycles, each bank tagged with its cycle number.
- Response: reads return tags in order; wr_ptr=1 at the end.
REQ-027 Reset:
- Stimulus: rst with full_cnt=2 and rd_en active.
- Response: next cycle full_cnt=0, rd_valid=0, rd_data=0, err=0.
